// File: rtl/puf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// puf_eval_ctrl
//
// Sequencer for the arbiter PUF array. It takes one challenge from the host
// and drives it onto the PUF challenge bus. It then fires the race pulse
// N_EVAL times and synchronises the raw response after each pulse. Every
// response bit is majority-voted, and the voted word goes back to the host.
// This block is the only driver of the PUF pulse and challenge.
//
// Evaluation timing (defaults): SETTLE 2 cycles with pulse low, LAUNCH
// 3 cycles with pulse high, then SAMPLE 1 cycle with pulse still high.
// resp_valid rises N_EVAL*(SETTLE_CYC+CAPTURE_CYC+1) edges after the
// accepting edge.
//
// Optional feature: define PUF_UNSTABLE_MASK_EN to add resp_unstable. It
// flags every response bit whose evaluations did not all agree.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   chal_valid     in   host challenge valid
//   chal_ready     out  controller can accept a challenge (IDLE only)
//   chal_data      in   challenge word
//   puf_challenge  out  registered challenge to the PUF array
//   puf_pulse      out  registered race pulse to the PUF array
//   puf_response   in   raw arbiter outputs, asynchronous to clk
//   resp_valid     out  voted response available
//   resp_ready     in   host accepts the response
//   resp_data      out  majority-voted response
//   busy           out  high in any state other than IDLE
//   resp_unstable  out  (PUF_UNSTABLE_MASK_EN only) per-bit disagreement mask
// ---------------------------------------------------------------------------
module puf_eval_ctrl #(
    parameter int C_LENGTH    = 8,
    parameter int RESP_W      = 8,
    parameter int N_EVAL      = 5,
    parameter int SETTLE_CYC  = 2,
    parameter int CAPTURE_CYC = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chal_valid,
    output logic                chal_ready,
    input  logic [C_LENGTH-1:0] chal_data,
    output logic [C_LENGTH-1:0] puf_challenge,
    output logic                puf_pulse,
    input  logic [RESP_W-1:0]   puf_response,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [RESP_W-1:0]   resp_data,
    output logic                busy
`ifdef PUF_UNSTABLE_MASK_EN
    ,
    output logic [RESP_W-1:0]   resp_unstable
`endif
);

    // Vote counters hold 0..N_EVAL. The evaluation counter runs 0..N_EVAL-1.
    localparam int VW   = $clog2(N_EVAL + 1);
    localparam int EW   = $clog2(N_EVAL + 1);
    localparam int PMAX = (SETTLE_CYC > CAPTURE_CYC) ? SETTLE_CYC : CAPTURE_CYC;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [VW-1:0] HALF      = VW'(N_EVAL / 2);
    localparam logic [EW-1:0] LAST_EVAL = EW'(N_EVAL - 1);
    localparam logic [PW-1:0] SET_LAST  = PW'(SETTLE_CYC - 1);
    localparam logic [PW-1:0] CAP_LAST  = PW'(CAPTURE_CYC - 1);
`ifdef PUF_UNSTABLE_MASK_EN
    localparam logic [VW-1:0] ALL_VOTES = VW'(N_EVAL);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LAUNCH,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state;
    logic [PW-1:0]       phase_cnt;
    logic [EW-1:0]       eval_cnt;
    logic [VW-1:0]       vote     [RESP_W];
    logic [VW-1:0]       vote_nxt [RESP_W];
    logic [RESP_W-1:0]   sync_q1;
    logic [RESP_W-1:0]   resp_sync;
    logic [RESP_W-1:0]   maj_word;
`ifdef PUF_UNSTABLE_MASK_EN
    logic [RESP_W-1:0]   unst_word;
`endif

    // NOTE: puf_response comes from free-running arbiters with no timing
    // relation to clk. Two flops in series let a metastable first stage
    // resolve before any logic looks at the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            resp_sync <= '0;
        end else begin
            sync_q1   <= puf_response;
            resp_sync <= sync_q1;
        end
    end

    // Vote totals that include the sample being taken this cycle. The result
    // word can then be registered on the same edge that enters DONE.
    // NOTE: every variable written in this block gets a default first. Any
    // path that skips an assignment would otherwise infer a latch.
    always_comb begin
        maj_word = '0;
`ifdef PUF_UNSTABLE_MASK_EN
        unst_word = '0;
`endif
        for (int i = 0; i < RESP_W; i++) begin
            vote_nxt[i] = vote[i] + VW'(resp_sync[i]);
            maj_word[i] = (vote_nxt[i] > HALF);
`ifdef PUF_UNSTABLE_MASK_EN
            unst_word[i] = (vote_nxt[i] != '0) && (vote_nxt[i] != ALL_VOTES);
`endif
        end
    end

    // Main sequencer. Every output is registered here. The async reset drops
    // puf_pulse immediately and throws away any partial vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            phase_cnt     <= '0;
            eval_cnt      <= '0;
            chal_ready    <= 1'b1;
            puf_challenge <= '0;
            puf_pulse     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            busy          <= 1'b0;
`ifdef PUF_UNSTABLE_MASK_EN
            resp_unstable <= '0;
`endif
            // NOTE: the vote counters sit in a small per-bit register array.
            // They are reset explicitly so that an aborted run can never leak
            // votes into the next one.
            for (int i = 0; i < RESP_W; i++) begin
                vote[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // chal_ready is high throughout IDLE, so chal_valid alone
                    // completes the handshake here.
                    if (chal_valid) begin
                        puf_challenge <= chal_data;
                        eval_cnt      <= '0;
                        phase_cnt     <= '0;
                        chal_ready    <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_SETTLE;
                        for (int i = 0; i < RESP_W; i++) begin
                            vote[i] <= '0;
                        end
                    end
                end

                S_SETTLE: begin
                    if (phase_cnt == SET_LAST) begin
                        phase_cnt <= '0;
                        puf_pulse <= 1'b1;
                        state     <= S_LAUNCH;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_LAUNCH: begin
                    if (phase_cnt == CAP_LAST) begin
                        phase_cnt <= '0;
                        state     <= S_SAMPLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    // The pulse has been high long enough for the arbiter
                    // result to cross both synchroniser flops.
                    puf_pulse <= 1'b0;
                    for (int i = 0; i < RESP_W; i++) begin
                        vote[i] <= vote_nxt[i];
                    end
                    if (eval_cnt == LAST_EVAL) begin
                        resp_data  <= maj_word;
`ifdef PUF_UNSTABLE_MASK_EN
                        resp_unstable <= unst_word;
`endif
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        eval_cnt <= eval_cnt + 1'b1;
                        state    <= S_SETTLE;
                    end
                end

                S_DONE: begin
                    // Hold the result until the host takes it. There is
                    // deliberately no timeout.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        chal_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    puf_pulse  <= 1'b0;
                    resp_valid <= 1'b0;
                    chal_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_puf_eval_ctrl
//
// Self-checking bench for puf_eval_ctrl with default parameters.
//
// The PUF is modelled as returning ~challenge. A per-evaluation flip mask is
// XORed on top. Expected results come from counting ones across the
// evaluations. Build with +define+PUF_UNSTABLE_MASK_EN to check the
// unstable mask as well.
// ---------------------------------------------------------------------------
module tb_puf_eval_ctrl;

    localparam int N_EVAL  = 5;
    localparam int LATENCY = 30;
    localparam int WIN_LEN = 4;

    logic       clk;
    logic       rst_n;
    logic       chal_valid;
    logic       chal_ready;
    logic [7:0] chal_data;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic [7:0] puf_response;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       busy;
`ifdef PUF_UNSTABLE_MASK_EN
    logic [7:0] resp_unstable;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Flip mask applied to the ideal response on each evaluation.
    logic [7:0] flips [N_EVAL];
    int         eval_idx = 0;
    int         pulse_run = 0;
    int         win_q [$];
    int         chg_viol = 0;

    puf_eval_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .chal_valid    (chal_valid),
        .chal_ready    (chal_ready),
        .chal_data     (chal_data),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .puf_response  (puf_response),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
`ifdef PUF_UNSTABLE_MASK_EN
        .resp_unstable (resp_unstable),
`endif
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF array model. Each rising pulse launches one race. The result is
    // the ideal response ~challenge with this evaluation's flips applied.
    always @(posedge puf_pulse) begin
        if (eval_idx < N_EVAL) puf_response = ~puf_challenge ^ flips[eval_idx];
        eval_idx++;
    end

    // Measure the length of every pulse-high window in clock cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            pulse_run = 0;
        end else if (puf_pulse) begin
            pulse_run++;
        end else if (pulse_run > 0) begin
            win_q.push_back(pulse_run);
            pulse_run = 0;
        end
    end

    // The challenge must never move while a race is in flight.
    always @(puf_challenge) begin
        if (puf_pulse === 1'b1 && rst_n === 1'b1) chg_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Majority-vote reference: count the ones in each bit across evaluations.
    task automatic ref_vote(input logic [7:0] ch, output logic [7:0] maj, output logic [7:0] unst);
        logic [7:0] raw;
        int         cnt;
        maj  = '0;
        unst = '0;
        for (int b = 0; b < 8; b++) begin
            cnt = 0;
            for (int e = 0; e < N_EVAL; e++) begin
                raw = ~ch ^ flips[e];
                cnt += int'(raw[b]);
            end
            maj[b]  = (2 * cnt > N_EVAL);
            unst[b] = (cnt > 0) && (cnt < N_EVAL);
        end
    endtask

    // One complete transaction. The caller must be at a negedge. bp is the
    // number of cycles resp_ready stays low after resp_valid rises.
    task automatic run_txn(input logic [7:0] ch, input int bp, input bit hold_valid,
                           input bit expect_immediate);
        int         w;
        int         edges;
        logic [7:0] exp_data;
        logic [7:0] exp_unst;
        logic [7:0] held;
        ref_vote(ch, exp_data, exp_unst);

        w = 0;
        while (!chal_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("chal_ready_wait", 32'(chal_ready), 32'd1);
        if (expect_immediate) check("accept_after_handshake", 32'(w), 32'd0);

        win_q.delete();
        eval_idx   = 0;
        chal_data  = ch;
        chal_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chal_valid = hold_valid;
        check("chal_latched", 32'(puf_challenge), 32'(ch));
        check("busy_after_accept", 32'(busy), 32'd1);
        check("chal_ready_low", 32'(chal_ready), 32'd0);

        edges = 0;
        while (!resp_valid && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check("resp_latency", 32'(edges), 32'(LATENCY));
        check("resp_data", 32'(resp_data), 32'(exp_data));
`ifdef PUF_UNSTABLE_MASK_EN
        check("resp_unstable", 32'(resp_unstable), 32'(exp_unst));
`endif
        held       = resp_data;
        resp_ready = (bp == 0);
        for (int c = 0; c < bp; c++) begin
            if (!hold_valid) begin
                chal_valid = c[0];
                chal_data  = ~ch;
            end
            @(negedge clk);
            check("bp_valid_held", 32'(resp_valid), 32'd1);
            check("bp_data_held", 32'(resp_data), 32'(held));
            check("bp_chal_ready", 32'(chal_ready), 32'd0);
        end
        if (!hold_valid) chal_valid = 1'b0;
        chal_data  = ch;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_after_hs", 32'(resp_valid), 32'd0);
        check("chal_ready_after_hs", 32'(chal_ready), 32'd1);
        check("busy_after_hs", 32'(busy), 32'd0);
        check("chal_unchanged", 32'(puf_challenge), 32'(ch));
        check("pulse_windows", 32'(win_q.size()), 32'(N_EVAL));
        foreach (win_q[k]) check("pulse_window_len", 32'(win_q[k]), 32'(WIN_LEN));
    endtask

    task automatic clear_flips();
        for (int e = 0; e < N_EVAL; e++) flips[e] = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_chal_ready"}, 32'(chal_ready), 32'd1);
        check({tag, "_pulse"}, 32'(puf_pulse), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_challenge"}, 32'(puf_challenge), 32'd0);
        check({tag, "_resp_data"}, 32'(resp_data), 32'd0);
`ifdef PUF_UNSTABLE_MASK_EN
        check({tag, "_unstable"}, 32'(resp_unstable), 32'd0);
`endif
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n        = 1'b0;
        chal_valid   = 1'b0;
        chal_data    = 8'h00;
        resp_ready   = 1'b0;
        puf_response = 8'h00;
        clear_flips();

        // 1. Reset, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // 2. Stable PUF with resp_ready high.
        run_txn(8'hA5, 0, 1'b0, 1'b0);

        // 3. Noisy bit 0: flipped on two evaluations, then on three.
        flips[1] = 8'h01;
        flips[3] = 8'h01;
        run_txn(8'h5A, 0, 1'b0, 1'b0);
        flips[4] = 8'h01;
        run_txn(8'h5A, 0, 1'b0, 1'b0);
        clear_flips();

        // 4. Backpressure for 10 cycles, with ignored chal_valid pulses.
        run_txn(8'h96, 10, 1'b0, 1'b0);

        // 5. Reset while the pulse is high in the third evaluation.
        win_q.delete();
        eval_idx   = 0;
        chal_data  = 8'h00;
        chal_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chal_valid = 1'b0;
        w = 0;
        while (!(win_q.size() == 2 && puf_pulse) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("third_eval_reached", 32'(puf_pulse), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Flipping the zero bits once would tip them to 1 if the aborted
        // run had left votes behind.
        flips[0] = 8'h3C;
        run_txn(8'h3C, 0, 1'b0, 1'b0);
        clear_flips();

        // 6. Back-to-back challenges with chal_valid held high.
        run_txn(8'h01, 0, 1'b1, 1'b0);
        run_txn(8'hFF, 0, 1'b0, 1'b1);

        // Randomised challenges, sparse noise and random backpressure.
        for (int t = 0; t < 6; t++) begin
            for (int e = 0; e < N_EVAL; e++) flips[e] = 8'($urandom & $urandom & $urandom);
            run_txn(8'($urandom), int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end
        clear_flips();

        check("chal_stable_during_pulse", 32'(chg_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
Sequencer for the 8-stage arbiter PUF array.
- Accepts a challenge over a valid/ready handshake and drives it onto the PUF challenge bus.
- Fires the race pulse N_EVAL times and synchronises the 8-bit response after each pulse.
- Majority-votes each response bit and returns the voted word over a valid/ready handshake.
- Sits between the host/IO logic and the PUF array; it is the only driver of the PUF pulse and challenge.

Parameters:
C_LENGTH, 8, challenge width (mux stages per PUF chain)
RESP_W, 8, response width (number of PUF instances)
N_EVAL, 5, evaluations per challenge; must be odd, >=1
SETTLE_CYC, 2, cycles with pulse low and challenge stable before launch; >=1
CAPTURE_CYC, 3, cycles pulse held high before sampling; >=3 (covers 2-flop synchroniser)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
chal_valid  in  1  host challenge valid
chal_ready  out  1  controller can accept a challenge
chal_data  in  C_LENGTH  challenge word
puf_challenge  out  C_LENGTH  registered challenge to PUF array
puf_pulse  out  1  registered race pulse to PUF array
puf_response  in  RESP_W  raw PUF arbiter outputs (asynchronous to clk)
resp_valid  out  1  voted response available
resp_ready  in  1  host accepts response
resp_data  out  RESP_W  majority-voted response
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - Outputs: chal_ready=1, puf_pulse=0, puf_challenge=0, resp_valid=0, resp_data=0, busy=0.
  - Clears all counters and synchroniser flops.
- puf_response passes through a 2-flop synchroniser (resp_sync) every cycle, in all states.
- States:
  - IDLE: chal_ready=1. On chal_valid&&chal_ready:
    - latch chal_data into puf_challenge
    - clear per-bit vote counters (width clog2(N_EVAL+1)) and eval_cnt
    - go to SETTLE.
  - SETTLE: puf_pulse=0 for SETTLE_CYC cycles, then LAUNCH.
  - LAUNCH: puf_pulse=1 for CAPTURE_CYC cycles, then SAMPLE.
  - SAMPLE: one cycle, puf_pulse stays 1.
    - For each bit i, vote[i]+=resp_sync[i].
    - If eval_cnt==N_EVAL-1, go to DONE; else eval_cnt++ and go to SETTLE (pulse drops to 0 next cycle).
  - DONE: puf_pulse=0, resp_valid=1.
    - resp_data[i]=(vote[i] > N_EVAL/2), registered on DONE entry and stable while valid.
    - On resp_valid&&resp_ready: resp_valid=0, go to IDLE. chal_ready rises the cycle after the response handshake.
- chal_ready=0 in all states except IDLE. chal_valid outside IDLE is ignored and not queued.
- puf_challenge changes only on the IDLE accept edge. It never changes while puf_pulse=1.
- Latency: each evaluation takes SETTLE_CYC+CAPTURE_CYC+1 cycles.
  - resp_valid rises N_EVAL*(SETTLE_CYC+CAPTURE_CYC+1) edges after the accepting edge.
  - Defaults: 5*6 = 30 edges.
- resp_valid is held with resp_data stable until resp_ready. There is no timeout.
- resp_ready while resp_valid=0 has no effect.
- rst_n low mid-operation (any state): immediate return to reset values. puf_pulse drops asynchronously and any partial vote is discarded.
- busy = (state != IDLE), registered.

Optional Feature:
Macro PUF_UNSTABLE_MASK_EN.
- Defined:
  - Adds output port resp_unstable [RESP_W-1:0], updated together with resp_data.
  - Bit i = 1 iff 0 < vote[i] < N_EVAL, i.e. the bit disagreed across evaluations.
  - Reset value 0; held stable while resp_valid=1.
- Not defined: the port is absent and no extra logic is generated. All other behaviour is identical.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles, then 1. Required: chal_ready=1, puf_pulse=0, resp_valid=0, busy=0, puf_challenge=0x00.
2. Stable PUF, defaults. Bench model returns ~challenge; send chal_data=0xA5, resp_ready=1.
   - puf_challenge=0xA5 one edge after accept.
   - Exactly 5 puf_pulse high windows, each 4 cycles (LAUNCH+SAMPLE).
   - resp_valid rises 30 edges after accept with resp_data=0x5A; unstable mask=0x00 if enabled.
3. Noisy bit. Model flips bit0 on evaluations 1 and 3 only (true value 1).
   - resp_data bit0=1 (votes 3/5).
   - With PUF_UNSTABLE_MASK_EN: resp_unstable=0x01.
   - Flipping on 3 of 5 evaluations gives bit0=0.
4. Backpressure: resp_ready=0 for 10 cycles after resp_valid.
   - resp_valid and resp_data stay constant.
   - chal_valid pulses during the wait are ignored (chal_ready=0).
   - resp_ready=1: handshake completes; chal_ready=1 on the next cycle.
5. Reset mid-operation: assert rst_n=0 while puf_pulse=1 in the 3rd evaluation.
   - puf_pulse goes to 0 without waiting for clk; all outputs return to reset values.
   - A new challenge 0x3C after reset yields a full 30-cycle sequence, with no carry-over of votes.
6. Back-to-back challenges 0x01 then 0xFF, chal_valid held high and resp_ready=1.
   - Second accept occurs the cycle after the first response handshake.
   - Both responses are correct and in order; puf_challenge never changes while puf_pulse=1.
